// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit 5-stage CPU:
// opcodes, ALU function codes and the ID/EX control bundle.
package cpu_pkg;

    localparam int DATA_W     = 16;
    localparam int REG_ADDR_W = 4;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_BEQ   = 4'b0100;
    localparam logic [3:0] OP_BLT   = 4'b0101;
    localparam logic [3:0] OP_BGT   = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1011;
    localparam logic [3:0] OP_JUMP  = 4'b1100;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    localparam logic [3:0] FN_AND = 4'b0000;
    localparam logic [3:0] FN_OR  = 4'b0001;
    localparam logic [3:0] FN_ADD = 4'b1111;
    localparam logic [3:0] FN_SUB = 4'b1110;
    localparam logic [3:0] FN_SLL = 4'b1010;
    localparam logic [3:0] FN_SRL = 4'b1011;

    typedef struct packed {
        logic [3:0] funct;
        logic [1:0] signExt;
        logic       muxExTop;
        logic       muxExBot;
        logic       muxWb;
        logic       memRead;
        logic       memWrite;
        logic       regWrite;
        logic       regWrite0;
        logic       comparator;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '0;

    // Raw decode bits may be X on opcodes that ignore them;
    // force them to 0 unless the opcode actually uses them.
    function automatic ctrl_t qualify(ctrl_t raw, logic [3:0] op);
        ctrl_t c;
        c           = raw;
        c.memRead   = (op == OP_LOAD) ? raw.memRead : 1'b0;
        c.memWrite  = (op == OP_STORE) ? raw.memWrite : 1'b0;
        c.regWrite  = (op == OP_RTYPE || op == OP_LOAD)
                      ? raw.regWrite : 1'b0;
        c.regWrite0 = (op == OP_RTYPE) ? raw.regWrite0 : 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: the EX load writes a register
// that the instruction in decode reads.
module hazard_detect
    import cpu_pkg::*;
#(
    parameter int REG_ADDR_W = 4
) (
    input  logic                  idValid,
    input  logic                  exValid,
    input  logic                  exMemRead,
    input  logic [REG_ADDR_W-1:0] exRd,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    output logic                  hz
);

    assign hz = idValid & exValid & exMemRead
              & ((exRd == idRs1) | (exRd == idRs2));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush and sticky halt.
// Optional stall counter: define ID_EX_PERF_CNT_EN.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  idValid,
    input  logic [3:0]            idOpcode,
    input  logic [3:0]            idFunctCode,
    input  logic [1:0]            idSignExtend,
    input  logic                  idMuxEXtop,
    input  logic                  idMuxEXbottom,
    input  logic                  idMuxWB,
    input  logic                  idMemRead,
    input  logic                  idMemWrite,
    input  logic                  idRegWrite,
    input  logic                  idRegWrite0,
    input  logic                  idComparator,
    input  logic [REG_ADDR_W-1:0] idRs1,
    input  logic [REG_ADDR_W-1:0] idRs2,
    input  logic [REG_ADDR_W-1:0] idRd,
    input  logic [DATA_W-1:0]     idReadData1,
    input  logic [DATA_W-1:0]     idReadData2,
    input  logic [DATA_W-1:0]     idImm,
    input  logic [DATA_W-1:0]     idPc,
    input  logic                  flush,
    output logic                  exValid,
    output logic [3:0]            exFunctCode,
    output logic [1:0]            exSignExtend,
    output logic                  exMuxEXtop,
    output logic                  exMuxEXbottom,
    output logic                  exMuxWB,
    output logic                  exMemRead,
    output logic                  exMemWrite,
    output logic                  exRegWrite,
    output logic                  exRegWrite0,
    output logic                  exComparator,
    output logic [REG_ADDR_W-1:0] exRs1,
    output logic [REG_ADDR_W-1:0] exRs2,
    output logic [REG_ADDR_W-1:0] exRd,
    output logic [DATA_W-1:0]     exReadData1,
    output logic [DATA_W-1:0]     exReadData2,
    output logic [DATA_W-1:0]     exImm,
    output logic [DATA_W-1:0]     exPc,
`ifdef ID_EX_PERF_CNT_EN
    output logic [15:0]           stallCount,
`endif
    output logic                  stall,
    output logic                  halted
);

    logic                  valid_q, valid_d;
    ctrl_t                 ctrl_q, ctrl_d;
    logic [REG_ADDR_W-1:0] rs1_q, rs1_d;
    logic [REG_ADDR_W-1:0] rs2_q, rs2_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     rdata1_q, rdata1_d;
    logic [DATA_W-1:0]     rdata2_q, rdata2_d;
    logic [DATA_W-1:0]     imm_q, imm_d;
    logic [DATA_W-1:0]     pc_q, pc_d;
    logic                  halted_q, halted_d;
    logic                  hz;
    ctrl_t                 id_raw;

    assign id_raw = '{
        funct:      idFunctCode,
        signExt:    idSignExtend,
        muxExTop:   idMuxEXtop,
        muxExBot:   idMuxEXbottom,
        muxWb:      idMuxWB,
        memRead:    idMemRead,
        memWrite:   idMemWrite,
        regWrite:   idRegWrite,
        regWrite0:  idRegWrite0,
        comparator: idComparator
    };

    hazard_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_hazard (
        .idValid  (idValid),
        .exValid  (valid_q),
        .exMemRead(ctrl_q.memRead),
        .exRd     (rd_q),
        .idRs1    (idRs1),
        .idRs2    (idRs2),
        .hz       (hz)
    );

    assign stall = (hz & ~flush) | halted_q;

    // Next ID/EX contents: halt, flush or hazard load a bubble,
    // otherwise capture the qualified decode slot.
    always_comb begin
        valid_d  = 1'b0;
        ctrl_d   = BUBBLE;
        rs1_d    = '0;
        rs2_d    = '0;
        rd_d     = '0;
        rdata1_d = '0;
        rdata2_d = '0;
        imm_d    = '0;
        pc_d     = '0;
        halted_d = halted_q;
        if (!(halted_q || flush || hz)) begin
            valid_d  = idValid;
            ctrl_d   = qualify(id_raw, idOpcode);
            rs1_d    = idRs1;
            rs2_d    = idRs2;
            rd_d     = idRd;
            rdata1_d = idReadData1;
            rdata2_d = idReadData2;
            imm_d    = idImm;
            pc_d     = idPc;
            if (idValid && idOpcode == OP_HALT)
                halted_d = 1'b1;
        end
    end

    // ID/EX register and sticky halt flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            ctrl_q   <= BUBBLE;
            rs1_q    <= '0;
            rs2_q    <= '0;
            rd_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            ctrl_q   <= ctrl_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            rd_q     <= rd_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Count real load-use stalls, saturating at all ones.
    always_comb begin
        cnt_d = cnt_q;
        if (hz && !flush && !halted_q && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign stallCount = cnt_q;
`endif

    assign exValid       = valid_q;
    assign exFunctCode   = ctrl_q.funct;
    assign exSignExtend  = ctrl_q.signExt;
    assign exMuxEXtop    = ctrl_q.muxExTop;
    assign exMuxEXbottom = ctrl_q.muxExBot;
    assign exMuxWB       = ctrl_q.muxWb;
    assign exMemRead     = ctrl_q.memRead;
    assign exMemWrite    = ctrl_q.memWrite;
    assign exRegWrite    = ctrl_q.regWrite;
    assign exRegWrite0   = ctrl_q.regWrite0;
    assign exComparator  = ctrl_q.comparator;
    assign exRs1         = rs1_q;
    assign exRs2         = rs2_q;
    assign exRd          = rd_q;
    assign exReadData1   = rdata1_q;
    assign exReadData2   = rdata2_q;
    assign exImm         = imm_q;
    assign exPc          = pc_q;
    assign halted        = halted_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline boundary between decode and execute in the 5-stage 16-bit CPU.
- Captures decode-stage control signals, register operands and the immediate into the ID/EX register on each clock.
- Qualifies don't-care control bits to safe values and detects load-use hazards, stalling IF/ID and inserting a bubble when one occurs.
- Handles flush on branch or jump resolution and latches a sticky halt.

Parameters:
DATA_W, 16, operand/immediate/PC width
REG_ADDR_W, 4, register-file address width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
idValid  in  1  decode slot holds a real instruction
idOpcode  in  4  instruction [15:12]
idFunctCode  in  4  ALU function from control unit
idSignExtend  in  2  extend mode from control unit
idMuxEXtop  in  1  ALU A-source select
idMuxEXbottom  in  1  ALU B-source select
idMuxWB  in  1  writeback select
idMemRead  in  1  raw control bit; may be X
idMemWrite  in  1  raw control bit; may be X
idRegWrite  in  1  raw control bit; may be X
idRegWrite0  in  1  raw control bit; may be X
idComparator  in  1  branch-compare enable
idRs1  in  REG_ADDR_W  source 1 address
idRs2  in  REG_ADDR_W  source 2 address
idRd  in  REG_ADDR_W  destination address
idReadData1  in  DATA_W  register-file port 1
idReadData2  in  DATA_W  register-file port 2
idImm  in  DATA_W  extended immediate
idPc  in  DATA_W  PC of the decode instruction
flush  in  1  branch taken or jump resolved; kill the decode slot
exValid  out  1  EX slot holds a real instruction
exFunctCode, exSignExtend, exMuxEXtop, exMuxEXbottom, exMuxWB, exMemRead, exMemWrite, exRegWrite, exRegWrite0, exComparator  out  same widths as inputs  registered control
exRs1, exRs2, exRd  out  REG_ADDR_W  registered addresses
exReadData1, exReadData2, exImm, exPc  out  DATA_W  registered data
stall  out  1  combinational; hold PC and IF/ID
halted  out  1  sticky halt

Behaviour:
- Reset (rst_n=0, asynchronous): every ex* output = 0, exValid=0, halted=0.
- Latency: one cycle, decode to ex*.
- Qualification at capture; qualification can never produce X on ex* control:
  - exMemRead = idMemRead only when idOpcode==4'b1000; otherwise 0.
  - exMemWrite = idMemWrite only when idOpcode==4'b1011; otherwise 0.
  - exRegWrite = idRegWrite only when idOpcode is 4'b0000 or 4'b1000; otherwise 0.
  - exRegWrite0 = idRegWrite0 only when idOpcode==4'b0000; otherwise 0.
  - Remaining control bits are captured unmodified.
- Hazard (combinational): hz = idValid & exValid & exMemRead & (exRd==idRs1 | exRd==idRs2).
- stall = (hz & ~flush) | halted.
- Priority at each rising edge, highest first:
  1. halted: load a bubble.
  2. flush: load a bubble; stall deasserted unless halted.
  3. hz: load a bubble; IF/ID holds, so the same decode is re-presented next cycle.
  4. Otherwise: capture the decode slot; exValid = idValid.
- Bubble: exValid=0 and all ex* control = 0. Data fields are don't-care; the design drives 0.
- Halt: a capture (case 4) with idValid=1 and idOpcode==4'b1111 sets halted on the same edge. Only rst_n clears it.
- Reset mid-stall or mid-flush: all state cleared immediately; stall re-evaluates from the reset outputs.
- Back-to-back loads with a dependency produce exactly one bubble each.

Optional Feature:
ID_EX_PERF_CNT_EN:
- Defined: adds output stallCount[15:0]. It increments on each edge where hz & ~flush & ~halted and saturates at 16'hFFFF. Reset value is 0.
- Undefined: no port, no counter logic.

Decomposition:
- Shared package, cpu_pkg:
  - Opcode constants: OP_RTYPE=0000, OP_LOAD=1000, OP_STORE=1011, OP_BEQ/BLT/BGT=0100/0101/0110, OP_JUMP=1100, OP_HALT=1111.
  - Function-code constants.
  - Control-bundle typedef with a BUBBLE constant.
- Sub-module hazard_detect: the combinational load-use compare producing hz.

Test Plan:
1. Reset with rst_n low mid-cycle -> all ex* = 0, halted=0 immediately, without waiting for an edge.
2. ADD (op 0000, funct 1111, memRead=X) -> next cycle exRegWrite=1, exMemRead=0, exFunctCode=1111, exValid=1.
3. EX = LOAD with rd=3, decode = ADD with rs2=3 -> stall=1 for one cycle and a bubble is inserted. The following cycle ADD is captured and stall=0. With ID_EX_PERF_CNT_EN, stallCount=1.
4. Hazard and flush in the same cycle -> bubble, stall=0, decode not re-presented.
5. Decode HALT (1111) -> halted=1 and stall=1 thereafter, exValid=0 permanently until rst_n pulses low.
6. STORE (1011, memWrite=1, regWrite=X) -> exMemWrite=1, exRegWrite=0, exRegWrite0=0, exImm=idImm.
